// File: rtl/spi_bus_arb_pkg.sv
// Shared definitions for the SPI bus arbiter: target codes, FSM states, response words.
// No logic of its own; latency not applicable.
// No flow control; constants and a pure decode helper only.
package spi_bus_arb_pkg;

  localparam int NREQ = 3;

  // Target codes carried in req_tgt, one per requester
  localparam logic [2:0] TGT_CH1  = 3'd0;
  localparam logic [2:0] TGT_CH2  = 3'd1;
  localparam logic [2:0] TGT_CH3  = 3'd2;
  localparam logic [2:0] TGT_TRIG = 3'd3;
  localparam logic [2:0] TGT_EEP  = 3'd4;

  // Response words returned when no real MISO data exists
  localparam logic [15:0] RSP_BAD = 16'h0000;
  localparam logic [15:0] RSP_TMO = 16'hFFFF;

  // All selects released
  localparam logic [4:0] SS_NONE = 5'h1F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_XFER,
    ST_DONE,
    ST_GAP
  } state_t;

  function automatic logic tgt_ok(input logic [2:0] tgt);
    return (tgt <= TGT_EEP);
  endfunction

  // Active-low one-cold select for a target; unknown codes select nothing
  function automatic logic [4:0] tgt_ssn(input logic [2:0] tgt);
    logic [4:0] s;
    case (tgt)
      TGT_CH1:  s = 5'b11110;
      TGT_CH2:  s = 5'b11101;
      TGT_CH3:  s = 5'b11011;
      TGT_TRIG: s = 5'b10111;
      TGT_EEP:  s = 5'b01111;
      default:  s = SS_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/spi_bus_arb_rr_arb3.sv
// 3-way round-robin picker; search starts one past the last served requester.
// Winner is combinational from req_i; pointer moves one cycle after upd_i.
// No backpressure; caller decides when a pick is consumed via upd_i.
module rr_arb3
  import spi_bus_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_i,
  input  logic       upd_i,
  input  logic [1:0] upd_idx_i,
  output logic [2:0] win_o,
  output logic [1:0] win_idx_o
);

  logic [1:0] ptr_q, ptr_d;
  logic [2:0] sum;
  logic [1:0] cand;
  logic       found;

  // Next search start is the requester after the one just served
  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) begin
      ptr_d = (upd_idx_i == 2'd2) ? 2'd0 : upd_idx_i + 2'd1;
    end
  end

  // Pointer register; reset gives requester 0 highest priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Scan requesters starting at the pointer, first hit wins
  always_comb begin
    win_o     = 3'b000;
    win_idx_o = 2'd0;
    found     = 1'b0;
    sum       = 3'd0;
    cand      = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + 3'(k);
      if (sum > 3'd2) begin
        sum = sum - 3'd3;
      end
      cand = sum[1:0];
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        win_o[cand] = 1'b1;
        win_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arb.sv
// Shares one SPI master among three requesters, one 16-bit transaction per grant.
// req in IDLE cycle N -> gnt N+1, ss_n/spi_wrt N+2; spi_done at M -> done/rsp M+1.
// Requesters wait on held req; transactions end on spi_done, timeout or bad target.
module spi_bus_arb
  import spi_bus_arb_pkg::*;
#(
  parameter int TMO_CYC = 4096,
  parameter int GAP_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [47:0] req_cmd,
  input  logic [8:0]  req_tgt,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic [15:0] rsp,
  output logic        err,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd,
  output logic [4:0]  ss_n
);

  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  state_t        state_q;
  logic [2:0]    gnt_q;
  logic [2:0]    done_q;
  logic [15:0]   rsp_q;
  logic          err_q;
  logic          spi_wrt_q;
  logic [15:0]   spi_cmd_q;
  logic [4:0]    ss_n_q;
  logic [1:0]    idx_q;
  logic [15:0]   cmd_q;
  logic [2:0]    tgt_q;
  logic [TW-1:0] tmo_cnt_q;
  logic [GW-1:0] gap_cnt_q;

  logic [2:0]    win_oh;
  logic [1:0]    win_idx;
  logic [15:0]   win_cmd;
  logic [2:0]    win_tgt;

  rr_arb3 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .upd_i     (state_q == ST_DONE),
    .upd_idx_i (idx_q),
    .win_o     (win_oh),
    .win_idx_o (win_idx)
  );

  // Pick the winner's command word and target out of the packed request buses
  always_comb begin
    win_cmd = req_cmd[15:0];
    win_tgt = req_tgt[2:0];
    case (win_idx)
      2'd1: begin
        win_cmd = req_cmd[31:16];
        win_tgt = req_tgt[5:3];
      end
      2'd2: begin
        win_cmd = req_cmd[47:32];
        win_tgt = req_tgt[8:6];
      end
      default: ;
    endcase
  end

  // Transaction sequencer with registered outputs; single-cycle pulses default low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 3'b000;
      done_q    <= 3'b000;
      rsp_q     <= 16'h0000;
      err_q     <= 1'b0;
      spi_wrt_q <= 1'b0;
      spi_cmd_q <= 16'h0000;
      ss_n_q    <= SS_NONE;
      idx_q     <= 2'd0;
      cmd_q     <= 16'h0000;
      tgt_q     <= 3'd0;
      tmo_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      spi_wrt_q <= 1'b0;
      done_q    <= 3'b000;
      err_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            idx_q   <= win_idx;
            cmd_q   <= win_cmd;
            tgt_q   <= win_tgt;
            gnt_q   <= win_oh;
            state_q <= ST_SEL;
          end
        end
        ST_SEL: begin
          if (tgt_ok(tgt_q)) begin
            ss_n_q    <= tgt_ssn(tgt_q);
            spi_wrt_q <= 1'b1;
            spi_cmd_q <= cmd_q;
            tmo_cnt_q <= '0;
            state_q   <= ST_XFER;
          end else begin
            // Unknown target: never touch the bus, report the error straight away
            rsp_q   <= RSP_BAD;
            err_q   <= 1'b1;
            done_q  <= gnt_q;
            state_q <= ST_DONE;
          end
        end
        ST_XFER: begin
          if (spi_done) begin
            rsp_q   <= spi_rd;
            done_q  <= gnt_q;
            ss_n_q  <= SS_NONE;
            state_q <= ST_DONE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            rsp_q   <= RSP_TMO;
            err_q   <= 1'b1;
            done_q  <= gnt_q;
            ss_n_q  <= SS_NONE;
            state_q <= ST_DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end
        ST_DONE: begin
          gnt_q     <= 3'b000;
          gap_cnt_q <= '0;
          state_q   <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign rsp     = rsp_q;
  assign err     = err_q;
  assign spi_wrt = spi_wrt_q;
  assign spi_cmd = spi_cmd_q;
  assign ss_n    = ss_n_q;

endmodule

// File: tb/tb_spi_bus_arb.sv
// Bench for spi_bus_arb: transaction-timeline model plus directed and random traffic.
// Model predicts each output per cycle from grant time, target and SPI completion.
// Requesters hold req until done; SPI master replies after a programmable delay.
module tb_spi_bus_arb;

  localparam int TMO = 4096;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic [47:0] req_cmd = '0;
  logic [8:0]  req_tgt = '0;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rd = '0;
  logic [2:0]  gnt, done;
  logic [15:0] rsp, spi_cmd;
  logic        err, spi_wrt;
  logic [4:0]  ss_n;

  spi_bus_arb #(.TMO_CYC(TMO), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_cmd(req_cmd), .req_tgt(req_tgt),
    .gnt(gnt), .done(done), .rsp(rsp), .err(err), .spi_wrt(spi_wrt),
    .spi_cmd(spi_cmd), .spi_done(spi_done), .spi_rd(spi_rd), .ss_n(ss_n)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // stimulus agent knobs
  int rearm_pct = 0, spur_pct = 0, mst_dly = -1, mst_rd = -1, mst_cnt = -1;
  bit mst_mute = 1'b0;

  // model state: transaction timeline in clock edges since reset
  int          edge_n = 0, m_e = 0, m_own = 0, m_free = 0, m_ptr = 0;
  bit          m_act = 1'b0, m_drop = 1'b0;
  logic [2:0]  m_tgt = '0;
  logic [15:0] m_cmd = '0;
  logic [2:0]  exp_gnt = '0, exp_done = '0;
  logic [15:0] exp_rsp = '0, exp_cmd = '0;
  logic        exp_err = 1'b0, exp_wrt = 1'b0;
  logic [4:0]  exp_ss = 5'h1F;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_finish(input logic [15:0] r, input logic e);
    exp_done = exp_gnt;
    exp_rsp  = r;
    exp_err  = e;
    exp_ss   = 5'h1F;
    m_act    = 1'b0;
    m_drop   = 1'b1;
    m_ptr    = (m_own + 1) % 3;
    m_free   = edge_n + GAP + 2;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_n = 0; m_act = 0; m_drop = 0; m_ptr = 0; m_free = 0;
      exp_gnt = '0; exp_done = '0; exp_rsp = '0; exp_err = 0;
      exp_wrt = 0; exp_cmd = '0; exp_ss = 5'h1F;
    end else begin
      edge_n++;
      exp_done = '0; exp_err = 1'b0; exp_wrt = 1'b0;
      if (m_drop) begin
        exp_gnt = '0;
        m_drop  = 1'b0;
      end
      if (!m_act) begin
        if (edge_n >= m_free && req != 3'b000) begin
          m_own = -1;
          for (int k = 0; k < 3; k++)
            if (m_own < 0 && req[(m_ptr + k) % 3]) m_own = (m_ptr + k) % 3;
          m_tgt   = req_tgt[3*m_own +: 3];
          m_cmd   = req_cmd[16*m_own +: 16];
          exp_gnt = 3'(1 << m_own);
          m_e     = edge_n;
          m_act   = 1'b1;
        end
      end else if (edge_n == m_e + 1) begin
        if (m_tgt > 3'd4) m_finish(16'h0000, 1'b1);
        else begin
          exp_ss  = ~(5'(1 << m_tgt));
          exp_wrt = 1'b1;
          exp_cmd = m_cmd;
        end
      end else begin
        if (spi_done) m_finish(spi_rd, 1'b0);
        else if (edge_n == m_e + 1 + TMO) m_finish(16'hFFFF, 1'b1);
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("done", 32'(done), 32'(exp_done));
      chk("rsp", 32'(rsp), 32'(exp_rsp));
      chk("err", 32'(err), 32'(exp_err));
      chk("spi_wrt", 32'(spi_wrt), 32'(exp_wrt));
      chk("spi_cmd", 32'(spi_cmd), 32'(exp_cmd));
      chk("ss_n", 32'(ss_n), 32'(exp_ss));
      chk("ss_onecold", 32'($countones(~ss_n) <= 1), 32'd1);
    end
  end

  task automatic step();
    @(negedge clk);
    spi_done = 1'b0;
    spi_rd   = 16'($urandom);
    if (spi_wrt) mst_cnt = mst_mute ? -1 : (mst_dly > 0 ? mst_dly : int'($urandom_range(30, 1)));
    else if (mst_cnt > 0) begin
      mst_cnt--;
      if (mst_cnt == 0) begin
        spi_done = 1'b1;
        if (mst_rd >= 0) spi_rd = 16'(mst_rd);
      end
    end
    if (!spi_done && int'($urandom_range(99)) < spur_pct) spi_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (done[i]) req[i] = 1'b0;
      else if (!req[i] && int'($urandom_range(99)) < rearm_pct) begin
        req[i] = 1'b1;
        req_cmd[16*i +: 16] = 16'($urandom);
        req_tgt[3*i +: 3] = (int'($urandom_range(9)) < 8) ? 3'($urandom_range(4)) : 3'($urandom_range(7, 5));
      end
    end
  endtask

  function automatic bit sig_hit(input int which);
    case (which)
      0: return |done;
      1: return spi_wrt;
      2: return |gnt;
      3: return (gnt == 3'b000) && (req == 3'b000);
      default: return ss_n == 5'h17;
    endcase
  endfunction

  task automatic wait_sig(input string nm, input int which, input int limit, output int n);
    bit hit;
    n = 0;
    hit = sig_hit(which);
    while (!hit && n < limit) begin
      step();
      n++;
      hit = sig_hit(which);
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL %s: timeout after %0d cycles", nm, limit);
    end
  endtask

  task automatic settle();
    int n;
    wait_sig("idle", 3, 2000, n);
    repeat (GAP + 3) step();
  endtask

  int n, ng, run, prev_g;
  int ord[4];
  bit started, got;

  initial begin
    // reset values
    @(posedge clk);
    #1 chk_en = 1'b1;
    step(); step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ss", 32'(ss_n), 32'h1F);
    chk("rst_rsp", 32'(rsp), 32'd0);
    chk("rst_cmd", 32'(spi_cmd), 32'd0);
    rst_n = 1'b1;
    step();

    // 1: single write to ch2 gain pot
    req[0] = 1'b1; req_cmd[15:0] = 16'h1302; req_tgt[2:0] = 3'd1;
    mst_dly = 20; mst_rd = 16'hA5A5;
    step();
    chk("t1_gnt", 32'(gnt), 32'h1);
    step();
    chk("t1_wrt", 32'(spi_wrt), 32'h1);
    chk("t1_ss", 32'(ss_n), 32'h1D);
    chk("t1_cmd", 32'(spi_cmd), 32'h1302);
    wait_sig("t1_done_wait", 0, 100, n);
    chk("t1_lat", 32'(n), 32'd21);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_rsp", 32'(rsp), 32'hA5A5);
    chk("t1_err", 32'(err), 32'h0);
    mst_dly = -1; mst_rd = -1;
    settle();

    // 5: async reset in XFER, pointer returns to requester 0
    req[0] = 1'b1; req_tgt[2:0] = 3'd3; mst_mute = 1'b1;
    wait_sig("t5_ss_wait", 4, 10, n);
    #2 rst_n = 1'b0;
    #1 chk("t5_ss", 32'(ss_n), 32'h1F);
    chk("t5_gnt", 32'(gnt), 32'h0);
    step(); step();
    mst_mute = 1'b0; mst_cnt = -1;
    req = 3'b011; req_tgt[2:0] = 3'd0; req_tgt[5:3] = 3'd2;
    rst_n = 1'b1;
    wait_sig("t5_gnt_wait", 2, 10, n);
    chk("t5_first", 32'(gnt), 32'h1);
    settle();

    // 3: EEPROM access with no SPI reply times out
    req[2] = 1'b1; req_tgt[8:6] = 3'd4; req_cmd[47:32] = 16'h0300; mst_mute = 1'b1;
    wait_sig("t3_wrt_wait", 1, 10, n);
    wait_sig("t3_done_wait", 0, TMO + 50, n);
    chk("t3_lat", 32'(n), 32'(TMO));
    chk("t3_done", 32'(done), 32'h4);
    chk("t3_err", 32'(err), 32'h1);
    chk("t3_rsp", 32'(rsp), 32'hFFFF);
    chk("t3_ss", 32'(ss_n), 32'h1F);
    mst_mute = 1'b0;
    step(); spi_done = 1'b1;
    step();
    chk("t3_late_done", 32'(done), 32'h0);
    chk("t3_late_err", 32'(err), 32'h0);
    settle();

    // 2: all three held, round-robin order and inter-grant gap
    rearm_pct = 100;
    req = 3'b111; req_tgt = {3'd2, 3'd1, 3'd0};
    ng = 0; run = 0; prev_g = 0; started = 1'b0; n = 0;
    while (ng < 4 && n < 600) begin
      step();
      n++;
      if (gnt != 3'b000 && prev_g == 0) begin
        ord[ng] = gnt[1] ? 1 : (gnt[2] ? 2 : 0);
        ng++;
      end
      if (ss_n == 5'h1F) run++;
      else begin
        if (run > 0 && started) chk("t2_gap", 32'(run >= GAP), 32'd1);
        started = 1'b1;
        run = 0;
      end
      prev_g = int'(gnt);
    end
    if (ng < 4) begin
      total++; bad++;
      $display("FAIL t2_grants: got %0d grants want 4", ng);
    end else begin
      chk("t2_ord0", 32'(ord[0]), 32'd0);
      chk("t2_ord1", 32'(ord[1]), 32'd1);
      chk("t2_ord2", 32'(ord[2]), 32'd2);
      chk("t2_ord3", 32'(ord[3]), 32'd0);
    end
    rearm_pct = 0;
    settle();

    // 4: bad target never touches the bus
    req[1] = 1'b1; req_tgt[5:3] = 3'd6;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      chk("t4_wrt", 32'(spi_wrt), 32'h0);
      chk("t4_ss", 32'(ss_n), 32'h1F);
      if (|done) begin
        got = 1'b1;
        chk("t4_done", 32'(done), 32'h2);
        chk("t4_err", 32'(err), 32'h1);
        chk("t4_rsp", 32'(rsp), 32'h0);
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL t4_done: no done within 12 cycles");
    end
    settle();

    // 6: stray spi_done in IDLE, then req0 dropped mid-transfer
    step(); spi_done = 1'b1;
    step();
    chk("t6_spur", 32'(done), 32'h0);
    req[0] = 1'b1; req_tgt[2:0] = 3'd0; mst_dly = 10;
    wait_sig("t6_wrt_wait", 1, 10, n);
    repeat (3) step();
    req[0] = 1'b0;
    wait_sig("t6_done_wait", 0, 40, n);
    chk("t6_done", 32'(done), 32'h1);
    chk("t6_err", 32'(err), 32'h0);
    mst_dly = -1;
    settle();

    // random traffic with stray spi_done pulses
    rearm_pct = 25; spur_pct = 2;
    for (int i = 0; i < 3000; i++) step();
    rearm_pct = 0; spur_pct = 0;
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
